// File: rtl/data_mem_arbiter.sv
// Arbitrates the single-port data RAM between the CPU MEM stage and the UART load/dump engine.
// Define ARB_ROUND_ROBIN_EN for strict alternation instead of CPU priority with starvation promotion.
module data_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  excl,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  input  logic                  uart_req,
  input  logic                  uart_we,
  input  logic [ADDR_WIDTH-1:0] uart_addr,
  input  logic [DATA_WIDTH-1:0] uart_wdata,
  output logic                  uart_gnt,
  output logic                  uart_rvalid,
  output logic [DATA_WIDTH-1:0] uart_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [0:0] CPU_PRI    = 1'b0;
  localparam logic [0:0] UART_PRI   = 1'b1;
  localparam logic       OWNER_CPU  = 1'b0;
  localparam logic       OWNER_UART = 1'b1;

  logic [0:0] pri_q, pri_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_owner_q, rd_owner_d;

  // Grant decision; nothing is granted while reset is held
  always_comb begin
    cpu_gnt  = 1'b0;
    uart_gnt = 1'b0;
    if (!reset) begin
      if (excl) begin
        uart_gnt = uart_req;
      end else if (cpu_req && uart_req) begin
        if (pri_q == UART_PRI) uart_gnt = 1'b1;
        else                   cpu_gnt  = 1'b1;
      end else begin
        cpu_gnt  = cpu_req;
        uart_gnt = uart_req;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // RAM port mux; idle port is driven to zero
  always_comb begin
    mem_en    = cpu_gnt | uart_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (uart_gnt) begin
      mem_we    = uart_we;
      mem_addr  = uart_addr;
      mem_wdata = uart_wdata;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // After each contended grant, favour the requester that lost
  always_comb begin
    pri_d = pri_q;
    if (excl) begin
      pri_d = CPU_PRI;
    end else if (cpu_req && uart_req) begin
      pri_d = cpu_gnt ? UART_PRI : CPU_PRI;
    end
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;

  // Promote the UART once it has been denied LIMIT times in a row
  always_comb begin
    starve_d = starve_q;
    pri_d    = pri_q;
    if (excl) begin
      starve_d = '0;
      pri_d    = CPU_PRI;
    end else begin
      if (uart_gnt) begin
        starve_d = '0;
      end else if (uart_req && (starve_q != LIMIT)) begin
        starve_d = starve_q + 4'd1;
      end
      case (pri_q)
        CPU_PRI:  if (starve_d == LIMIT) pri_d = UART_PRI;
        UART_PRI: if (uart_gnt)          pri_d = CPU_PRI;
        default:  pri_d = CPU_PRI;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pri_q <= CPU_PRI;
    else       pri_q <= pri_d;
  end

  assign rd_pend_d  = (cpu_gnt & ~cpu_we) | (uart_gnt & ~uart_we);
  assign rd_owner_d = uart_gnt ? OWNER_UART : OWNER_CPU;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWNER_CPU;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // RAM data arrives one cycle after the read grant; route it to its owner only
  assign cpu_rvalid  = rd_pend_q & (rd_owner_q == OWNER_CPU);
  assign uart_rvalid = rd_pend_q & (rd_owner_q == OWNER_UART);
  assign cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
  assign uart_rdata  = uart_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: a rule-level model predicts grants and read responses,
// a separate monitor compares them against the DUT every cycle.
module tb_data_mem_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned LIMIT = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          excl;
  logic          cpu_req, cpu_we, uart_req, uart_we;
  logic [AW-1:0] cpu_addr, uart_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, uart_wdata, mem_wdata;
  logic          cpu_gnt, cpu_stall, cpu_rvalid, uart_gnt, uart_rvalid, mem_en, mem_we;
  logic [DW-1:0] cpu_rdata, uart_rdata;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .excl(excl),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr), .uart_wdata(uart_wdata),
    .uart_gnt(uart_gnt), .uart_rvalid(uart_rvalid), .uart_rdata(uart_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // Write-first synchronous RAM attached to the arbiter
  logic [31:0] ram [int];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[int'(mem_addr)] = mem_wdata;
        mem_rdata <= mem_wdata;
      end else begin
        mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : mem_default(mem_addr);
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [int];
  bit          m_fav_uart;
  int          m_wait;
  typedef struct { int due; bit uart; logic [31:0] data; } rsp_t;
  rsp_t        exp_q[$];
  rsp_t        rsp;
  bit          d_excl, d_creq, d_ureq, d_cg, d_ug;
  logic        e_cg, e_ug, e_stall, e_en, e_we;
  logic [31:0] e_addr, e_wdata;
  int          cyc;
  int          checks, passes;
  bit          run;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : mem_default(a);
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    checks++;
    if (act === exp_v) passes++;
    else $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp_v);
  endtask

  task automatic clear_expect();
    {e_cg, e_ug, e_stall, e_en, e_we} = '0;
    e_addr = '0; e_wdata = '0;
    {d_excl, d_creq, d_ureq, d_cg, d_ug} = '0;
  endtask

  // Update the fairness state with the outcome of the cycle that just ended
  task automatic commit();
`ifdef ARB_ROUND_ROBIN_EN
    if (d_excl) m_fav_uart = 1'b0;
    else if (d_creq && d_ureq) m_fav_uart = d_cg;
`else
    if (d_excl) begin
      m_wait = 0; m_fav_uart = 1'b0;
    end else if (d_ug) begin
      m_wait = 0; m_fav_uart = 1'b0;
    end else begin
      if (d_ureq && m_wait < int'(LIMIT)) m_wait++;
      if (m_wait == int'(LIMIT)) m_fav_uart = 1'b1;
    end
`endif
  endtask

  task automatic cycle(input bit x, input bit cr, input bit cw, input logic [31:0] ca,
                       input logic [31:0] cd, input bit ur, input bit uw,
                       input logic [31:0] ua, input logic [31:0] ud);
    bit cg, ug;
    @(posedge clk);
    commit();
    cyc++;
    #1;
    excl = x; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    uart_req = ur; uart_we = uw; uart_addr = ua; uart_wdata = ud;
    if (x) begin cg = 1'b0; ug = ur; end
    else if (cr && ur) begin ug = m_fav_uart; cg = !m_fav_uart; end
    else begin cg = cr; ug = ur; end
    {d_excl, d_creq, d_ureq, d_cg, d_ug} = {x, cr, ur, cg, ug};
    e_cg = cg; e_ug = ug; e_stall = cr && !cg; e_en = cg || ug;
    e_we    = cg ? cw : (ug ? uw : 1'b0);
    e_addr  = cg ? ca : (ug ? ua : 32'h0);
    e_wdata = cg ? cd : (ug ? ud : 32'h0);
    if (cg) begin
      if (cw) ref_mem[int'(ca)] = cd;
      else exp_q.push_back('{due: cyc + 1, uart: 1'b0, data: ref_rd(ca)});
    end
    if (ug) begin
      if (uw) ref_mem[int'(ua)] = ud;
      else exp_q.push_back('{due: cyc + 1, uart: 1'b1, data: ref_rd(ua)});
    end
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic model_reset();
    m_fav_uart = 1'b0; m_wait = 0;
    exp_q.delete();
    clear_expect();
  endtask

  // Monitor: compares the DUT against the expectations once per cycle
  always @(negedge clk) begin
    if (run) begin
      check("grant_stall", 128'({cpu_gnt, uart_gnt, cpu_stall}), 128'({e_cg, e_ug, e_stall}));
      check("mem_port", 128'({mem_en, mem_we, mem_addr, mem_wdata}),
            128'({e_en, e_we, e_addr, e_wdata}));
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        rsp = exp_q.pop_front();
        check("rvalid_route", 128'({cpu_rvalid, uart_rvalid}), 128'({!rsp.uart, rsp.uart}));
        check(rsp.uart ? "uart_rdata" : "cpu_rdata", 128'({cpu_rdata, uart_rdata}),
              rsp.uart ? 128'({32'h0, rsp.data}) : 128'({rsp.data, 32'h0}));
      end else begin
        check("no_response", 128'({cpu_rvalid, uart_rvalid, cpu_rdata, uart_rdata}), 128'(0));
      end
    end
  end

  bit          c_pend, c_we, u_pend, u_we, x_now;
  logic [31:0] c_addr, c_wd, u_addr, u_wd;
  logic [5:0]  pat;

  initial begin
    checks = 0; passes = 0; cyc = 0; pat = '0;
    reset = 1'b1; excl = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    uart_req = 1'b0; uart_we = 1'b0; uart_addr = '0; uart_wdata = '0;
    model_reset();
    run = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Sustained contention from a fresh state
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 32'h30, 32'(i), 1'b1, 1'b1, 32'h34, 32'(i + 100));
      #3 pat = {pat[4:0], uart_gnt};
    end
`ifdef ARB_ROUND_ROBIN_EN
    check("contention_pattern", 128'(pat), 128'(6'b010101));
`else
    check("contention_pattern", 128'(pat), 128'(6'b000010));
`endif
    idle();

    // CPU write then read back
    cycle(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();

    // Exclusive UART write while the CPU read waits, then the CPU read completes
    cycle(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b1, 1'b1, 32'h20, 32'h12345678);
    cycle(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();

    // Back-to-back reads from different owners
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    idle();
    idle();

    // Reset lands between a read grant and its response
    cycle(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    reset = 1'b1; cpu_req = 1'b0;
    model_reset();
    idle();
    idle();
    reset = 1'b0;
    idle();
    cycle(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b1, 1'b0, 32'hC, 32'h0);
    idle();

    // Randomized traffic; requesters hold their fields until granted
    c_pend = 1'b0; u_pend = 1'b0;
    c_we = 1'b0; u_we = 1'b0; c_addr = '0; u_addr = '0; c_wd = '0; u_wd = '0;
    for (int i = 0; i < 600; i++) begin
      if (!c_pend && $urandom_range(0, 2) != 0) begin
        c_pend = 1'b1; c_we = 1'($urandom_range(0, 1));
        c_addr = 32'($urandom_range(0, 15)) << 2; c_wd = $urandom;
      end
      if (!u_pend && $urandom_range(0, 2) != 0) begin
        u_pend = 1'b1; u_we = 1'($urandom_range(0, 1));
        u_addr = 32'($urandom_range(0, 15)) << 2; u_wd = $urandom;
      end
      x_now = ($urandom_range(0, 9) == 0);
      cycle(x_now, c_pend, c_we, c_addr, c_wd, u_pend, u_we, u_addr, u_wd);
      if (d_cg) c_pend = 1'b0;
      if (d_ug) u_pend = 1'b0;
    end
    repeat (3) idle();
    @(posedge clk);
    run = 1'b0;
    check("responses_drained", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Shares the single-port synchronous data RAM between the CPU MEM stage and the UART load/dump engine. Grants at most one access per cycle. Drives the RAM port and routes read data back to the requester that owns it. Raises a stall to freeze the CPU pipeline whenever the CPU's access is not granted. Sits between EX/MEM outputs, the UART engine and the data RAM inside the bus.

Parameters:
ADDR_WIDTH, 32, width of all address buses
DATA_WIDTH, 32, width of all data buses
STARVE_LIMIT, 4, consecutive denied UART cycles before UART gets priority (range 1..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
excl  in  1  UART exclusive mode (uart_on); CPU never granted while high
cpu_req  in  1  CPU access request
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  ADDR_WIDTH  CPU address
cpu_wdata  in  DATA_WIDTH  CPU write data
cpu_gnt  out  1  CPU access accepted this cycle
cpu_stall  out  1  cpu_req & ~cpu_gnt
cpu_rvalid  out  1  CPU read data valid
cpu_rdata  out  DATA_WIDTH  CPU read data
uart_req  in  1  UART access request
uart_we  in  1  UART write / read
uart_addr  in  ADDR_WIDTH  UART address
uart_wdata  in  DATA_WIDTH  UART write data
uart_gnt  out  1  UART access accepted this cycle
uart_rvalid  out  1  UART read data valid
uart_rdata  out  DATA_WIDTH  UART read data
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_WIDTH  RAM address
mem_wdata  out  DATA_WIDTH  RAM write data
mem_rdata  in  DATA_WIDTH  RAM read data, valid 1 cycle after mem_en & ~mem_we

Behaviour:
- Grant is combinational in the same cycle. A transaction completes when req & gnt at a rising edge. Requesters hold req/we/addr/wdata stable until granted.
- cpu_gnt and uart_gnt are never both 1.
- Priority FSM, state register pri_q: CPU_PRI (reset state) and UART_PRI.
  - CPU_PRI: CPU wins when both request (unless excl).
  - UART_PRI: UART wins. Returns to CPU_PRI on the cycle after a UART grant.
- Starvation counter starve_q, 4 bits:
  - Increments each cycle uart_req & ~uart_gnt, saturating at STARVE_LIMIT.
  - Clears on uart_gnt.
  - When starve_q == STARVE_LIMIT in CPU_PRI, moves to UART_PRI next cycle.
- excl=1: cpu_gnt=0, uart_gnt=uart_req, starve_q held at 0, FSM forced to CPU_PRI.
- No request: mem_en=0, and mem_we/mem_addr/mem_wdata driven to 0.
- Granted requester's fields drive the mem_* outputs; mem_en=1.
- Read response:
  - Registers rd_pend_q and rd_owner_q capture (gnt & ~we) and the owner.
  - Next cycle the owner's rvalid=1 and its rdata=mem_rdata. The other requester's rvalid=0 and rdata=0.
  - Back-to-back reads are allowed: one response per cycle, in grant order.
- Write has no response. A read granted the cycle after a write returns the new data; the RAM is write-first, and no bypass is needed here.
- Reset: pri_q=CPU_PRI, starve_q=0, rd_pend_q=0, rd_owner_q=CPU, so all rvalid=0, all rdata=0, gnt=0.
- Reset asserted mid-read drops the pending response; no rvalid appears after reset is released.
- cpu_stall is combinational: asserted in any cycle with cpu_req=1 and cpu_gnt=0, including under excl.

Optional Feature:
ARB_ROUND_ROBIN_EN
- Defined: the starvation counter and threshold are removed, and STARVE_LIMIT is ignored. When both request, grant alternates strictly: the FSM flips to favour the loser after every contended grant. Uncontended requests are granted immediately. excl behaviour is unchanged.
- Undefined: CPU-priority with starvation promotion, exactly as above.

Test Plan:
1. CPU read only: cpu_req=1, we=0, addr=0x10, RAM[0x10]=0xDEADBEEF -> cpu_gnt=1 and mem_en=1, mem_addr=0x10 the same cycle; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF; uart_rvalid=0.
2. Contention with starvation, STARVE_LIMIT=4: cpu_req and uart_req held high -> CPU granted 4 cycles, UART granted in cycle 5, CPU again in cycle 6; cpu_stall=1 only in cycle 5.
3. excl=1, cpu_req=1, uart write addr 0x20 data 0x12345678 -> uart_gnt=1, cpu_gnt=0, cpu_stall=1; then excl=0 and CPU reads 0x20 -> cpu_rdata=0x12345678.
4. Back-to-back reads: UART read at 0x4, next cycle CPU read at 0x8 -> uart_rvalid in cycle 2, cpu_rvalid in cycle 3, with the correct data each and no cross-routing.
5. Reset mid-operation: CPU read granted, reset asserted before the next edge -> cpu_rvalid stays 0; all outputs 0; FSM in CPU_PRI after release.
6. With ARB_ROUND_ROBIN_EN: both requesting continuously -> grants alternate CPU, UART, CPU, UART; cpu_stall asserted every second cycle.
